memory_io_bridge: RTL and testbench
===================================

Name: memory_io_bridge

Overview:
- Sits directly downstream of the processor's data-memory port: takes the processor's address, write-enable and write data, and returns its read data.
- Splits the address space into two regions: block RAM (everything below IO_BASE) and a small memory-mapped IO window (IO_BASE and above).
- The IO window holds a byte TX FIFO with a valid/ready output, a free-running timer and a GPIO output register.
- Keeps the processor's 1-cycle read latency: data for the address presented in cycle N appears on cpu_memory_out in cycle N+1.

Parameters:
ADDR_SIZE, 18, address width
WORD_SIZE, 18, data word width
IO_BASE, 18'h3FF00, first IO address; IO hit = (cpu_memory_addr >= IO_BASE); IO offset = addr[7:0]
FIFO_DEPTH_LOG2, 3, TX FIFO depth = 2**FIFO_DEPTH_LOG2 entries (8)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
cpu_memory_write_enable  in  1  write strobe from processor
cpu_memory_addr  in  ADDR_SIZE  address from processor
cpu_memory_in  in  WORD_SIZE  write data from processor
cpu_memory_out  out  WORD_SIZE  read data to processor, 1 cycle after address
ram_write_enable  out  1  = cpu_memory_write_enable & !io_hit
ram_addr  out  ADDR_SIZE  = cpu_memory_addr (always, combinational)
ram_in  out  WORD_SIZE  = cpu_memory_in
ram_out  in  WORD_SIZE  RAM read data, 1-cycle synchronous latency
tx_data  out  8  FIFO head byte
tx_valid  out  1  = FIFO not empty
tx_ready  in  1  consumer accepts; pop when tx_valid & tx_ready at posedge
gpio_out  out  WORD_SIZE  GPIO register

Behaviour:
- Reset values: FIFO empty (rd/wr pointers 0, count 0), tx_valid 0, overflow 0, timer 0, gpio_out 0, io_sel_q 0 (so cpu_memory_out passes ram_out).
- Read path:
  - Each cycle, register io_sel_q <= io_hit.
  - Each cycle, register io_rdata_q <= IO read value of the current offset (a snapshot taken in the address cycle).
  - cpu_memory_out = io_sel_q ? io_rdata_q : ram_out.
- IO map (offset), read / write:
  - 0x00 TX_DATA: read 0 / push cpu_memory_in[7:0].
  - 0x01 STATUS: read {count[FIFO_DEPTH_LOG2:0], overflow, full, empty} in bits [FIFO_DEPTH_LOG2+3:0], upper bits 0 / write with bit2=1 clears overflow, other bits ignored.
  - 0x02 TIMER: read counter / write loads cpu_memory_in.
  - 0x03 GPIO: read gpio_out / write loads it.
  - Other offsets: read 0, writes ignored.
- Writes never reach RAM when io_hit=1.
- FIFO push/pop rules:
  - A push is accepted when not full, or when full and a pop occurs in the same cycle (count unchanged, head advances).
  - A push to a full FIFO with no pop is dropped and sets overflow (sticky).
  - Simultaneous push and pop when empty: push accepted, no pop (tx_valid was 0).
  - Pointers wrap modulo depth; count ranges 0..2**FIFO_DEPTH_LOG2.
  - tx_data is stable while tx_valid=1 and no pop.
- Timer:
  - Increments by 1 every cycle and wraps from all-ones to 0.
  - A write wins over the increment: the loaded value is visible next cycle, and incrementing resumes the cycle after.
- Overflow priority: set and clear in the same cycle -> clear wins.
- Reset mid-operation: FIFO contents discarded, tx_valid drops in the cycle after reset is sampled. A read issued in the reset cycle returns ram_out.

Optional Feature:
- Macro: MEMORY_IO_BRIDGE_RX_EN.
- With the macro defined:
  - Adds ports rx_data in 8, rx_valid in 1, rx_ready out 1, backed by a 1-entry holding register.
  - rx_ready = !rx_full. A byte is captured when rx_valid & rx_ready.
  - Offset 0x04 reads {rx_full, 1'b0, rx_byte} (rx_full in bit 9, rx_byte in bits 7:0).
  - A read of offset 0x04 while rx_full clears rx_full, so the next byte can be accepted the following cycle.
  - Reset clears rx_full.
- Without the macro: the rx ports are absent and offset 0x04 reads 0.

Test Plan:
- RAM passthrough: write 18'h1234 to addr 0x00010, then read addr 0x00010 -> ram_write_enable=1 in the write cycle; cpu_memory_out=0x1234 one cycle after the read address.
- IO isolation: write 0x55 to IO_BASE+3 -> ram_write_enable=0, gpio_out=0x55 next cycle; read IO_BASE+3 -> 0x55 after 1 cycle.
- FIFO fill and overflow: tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS reads full=1, overflow=1, count=8. Set tx_ready=1 -> bytes 0x01..0x08 appear in order, then tx_valid=0. Write STATUS bit2 -> overflow=0.
- Push while full with simultaneous pop: 8 entries queued, tx_ready=1, push 0xAA -> accepted, count stays 8, overflow stays 0, and 0xAA is the last byte drained.
- Timer: write 0x3FFFE to IO_BASE+2, then read on each of the following cycles -> values 0x3FFFE, 0x3FFFF, 0x00000 (wrap), each returned one cycle after its address.
- Reset mid-drain: 5 bytes queued, assert reset for 1 cycle -> tx_valid=0, STATUS=empty, timer=0 and gpio_out=0 in the next cycle.

Source files
------------

// File: rtl/memory_io_bridge.sv
// Data-memory bridge: routes processor accesses to block RAM or an IO window
// (TX FIFO, timer, GPIO). Optional RX holding register via MEMORY_IO_BRIDGE_RX_EN.
module memory_io_bridge #(
  parameter int unsigned          ADDR_SIZE       = 18,
  parameter int unsigned          WORD_SIZE       = 18,
  parameter logic [ADDR_SIZE-1:0] IO_BASE         = 18'h3FF00,
  parameter int unsigned          FIFO_DEPTH_LOG2 = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_memory_write_enable,
  input  logic [ADDR_SIZE-1:0] cpu_memory_addr,
  input  logic [WORD_SIZE-1:0] cpu_memory_in,
  output logic [WORD_SIZE-1:0] cpu_memory_out,
  output logic                 ram_write_enable,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_in,
  input  logic [WORD_SIZE-1:0] ram_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [WORD_SIZE-1:0] gpio_out
`ifdef MEMORY_IO_BRIDGE_RX_EN
  ,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [7:0] {
    OFF_TX     = 8'h00,
    OFF_STATUS = 8'h01,
    OFF_TIMER  = 8'h02,
    OFF_GPIO   = 8'h03,
    OFF_RX     = 8'h04
  } io_reg_e;

  logic                       io_hit;
  logic [7:0]                 io_offset;
  logic                       io_write;

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [CNT_W-1:0]           count;
  logic                       full;
  logic                       empty;
  logic                       overflow;
  logic                       push_req;
  logic                       push_ok;
  logic                       pop;
  logic                       ovf_set;
  logic                       ovf_clr;

  logic [WORD_SIZE-1:0]       timer;
  logic [WORD_SIZE-1:0]       status_word;
  logic [WORD_SIZE-1:0]       io_rdata;
  logic [WORD_SIZE-1:0]       io_rdata_q;
  logic                       io_sel_q;

  // Address decode and RAM-side passthrough
  always_comb begin
    io_hit    = (cpu_memory_addr >= IO_BASE);
    io_offset = cpu_memory_addr[7:0];
    io_write  = cpu_memory_write_enable & io_hit;
  end

  assign ram_write_enable = cpu_memory_write_enable & ~io_hit;
  assign ram_addr         = cpu_memory_addr;
  assign ram_in           = cpu_memory_in;

  // TX FIFO control; a push into a full FIFO survives only if the head pops this cycle
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    tx_valid = ~empty;
    tx_data  = fifo_mem[rd_ptr];
    pop      = tx_valid & tx_ready;
    push_req = io_write && (io_offset == OFF_TX);
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    ovf_clr  = io_write && (io_offset == OFF_STATUS) && cpu_memory_in[2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= cpu_memory_in[7:0];
  end

  // Timer and GPIO; a timer write takes precedence over the increment
  always_ff @(posedge clock) begin
    if (reset) begin
      timer    <= '0;
      gpio_out <= '0;
    end else begin
      if (io_write && (io_offset == OFF_TIMER)) timer <= cpu_memory_in;
      else                                      timer <= timer + 1'b1;
      if (io_write && (io_offset == OFF_GPIO))  gpio_out <= cpu_memory_in;
    end
  end

`ifdef MEMORY_IO_BRIDGE_RX_EN
  logic       rx_full;
  logic [7:0] rx_byte;
  logic       rx_clr;

  assign rx_ready = ~rx_full;

  always_comb begin
    rx_clr = io_hit && !cpu_memory_write_enable && (io_offset == OFF_RX) && rx_full;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_byte <= '0;
    end else if (rx_valid && rx_ready) begin
      rx_full <= 1'b1;
      rx_byte <= rx_data;
    end else if (rx_clr) begin
      rx_full <= 1'b0;
    end
  end
`endif

  // IO read value of the current offset, captured in the address cycle
  always_comb begin
    status_word = '0;
    status_word[FIFO_DEPTH_LOG2+3:0] = {count, overflow, full, empty};
    io_rdata = '0;
    case (io_offset)
      OFF_STATUS: io_rdata = status_word;
      OFF_TIMER:  io_rdata = timer;
      OFF_GPIO:   io_rdata = gpio_out;
`ifdef MEMORY_IO_BRIDGE_RX_EN
      OFF_RX:     io_rdata[9:0] = {rx_full, 1'b0, rx_byte};
`endif
      default:    io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= io_hit;
      io_rdata_q <= io_rdata;
    end
  end

  assign cpu_memory_out = io_sel_q ? io_rdata_q : ram_out;

endmodule

// File: tb/tb_memory_io_bridge.sv
// Directed table-driven bench for memory_io_bridge with a 1-cycle RAM model.
module tb_memory_io_bridge;

  localparam logic [17:0] IO = 18'h3FF00;
  localparam int unsigned C_RWE = 1, C_OUT = 2, C_TX = 4, C_GP = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_memory_write_enable;
  logic [17:0] cpu_memory_addr;
  logic [17:0] cpu_memory_in;
  logic [17:0] cpu_memory_out;
  logic        ram_write_enable;
  logic [17:0] ram_addr;
  logic [17:0] ram_in;
  logic [17:0] ram_out = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [17:0] gpio_out;

  logic [17:0] ram [1024];

  int unsigned n_vec  = 0;
  int unsigned n_chk  = 0;
  int unsigned n_miss = 0;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [17:0] din;
    logic        rdy;
    int unsigned chk;
    logic        exp_rwe;
    logic [17:0] exp_out;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic [17:0] exp_gpio;
  } vec_t;

  vec_t vecs[$];

  memory_io_bridge #(
    .ADDR_SIZE(18),
    .WORD_SIZE(18),
    .IO_BASE(18'h3FF00),
    .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_memory_write_enable(cpu_memory_write_enable),
    .cpu_memory_addr(cpu_memory_addr),
    .cpu_memory_in(cpu_memory_in),
    .cpu_memory_out(cpu_memory_out),
    .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr),
    .ram_in(ram_in),
    .ram_out(ram_out),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .gpio_out(gpio_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_write_enable) ram[ram_addr[9:0]] <= ram_in;
    ram_out <= ram[ram_addr[9:0]];
  end

  function automatic vec_t mk(input logic we, input logic [17:0] addr, input logic [17:0] din,
                              input logic rdy, input int unsigned chk, input logic exp_rwe,
                              input logic [17:0] exp_out, input logic exp_txv,
                              input logic [7:0] exp_txd, input logic [17:0] exp_gpio);
    vec_t v;
    v.we = we; v.addr = addr; v.din = din; v.rdy = rdy; v.chk = chk;
    v.exp_rwe = exp_rwe; v.exp_out = exp_out; v.exp_txv = exp_txv;
    v.exp_txd = exp_txd; v.exp_gpio = exp_gpio;
    return v;
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector just after a posedge, check ram_we combinationally,
  // then check registered outputs just after the following posedge.
  task automatic step(input vec_t v, input string tag);
    cpu_memory_write_enable = v.we;
    cpu_memory_addr         = v.addr;
    cpu_memory_in           = v.din;
    tx_ready                = v.rdy;
    #2;
    n_vec++;
    if ((v.chk & C_RWE) != 0) chk({tag, " ram_we"}, 18'(ram_write_enable), 18'(v.exp_rwe));
    @(posedge clock);
    #1;
    if ((v.chk & C_OUT) != 0) chk({tag, " rdata"}, cpu_memory_out, v.exp_out);
    if ((v.chk & C_TX) != 0) begin
      chk({tag, " tx_valid"}, 18'(tx_valid), 18'(v.exp_txv));
      if (v.exp_txv) chk({tag, " tx_data"}, 18'(tx_data), 18'(v.exp_txd));
    end
    if ((v.chk & C_GP) != 0) chk({tag, " gpio"}, gpio_out, v.exp_gpio);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    reset = 1'b1;
    cpu_memory_write_enable = 1'b0;
    cpu_memory_addr = '0;
    cpu_memory_in = '0;
    tx_ready = 1'b0;

    // RAM passthrough, including the last RAM address below the IO window
    vecs.push_back(mk(1, 18'h00010, 18'h01234, 0, C_RWE, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 18'h00010, 0, 0, C_RWE | C_OUT, 0, 18'h01234, 0, 0, 0));
    vecs.push_back(mk(1, 18'h3FEFF, 18'h2AAAA, 0, C_RWE, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 18'h3FEFF, 0, 0, C_OUT, 0, 18'h2AAAA, 0, 0, 0));
    vecs.push_back(mk(1, 18'h00303, 18'h0ABCD, 0, C_RWE, 1, 0, 0, 0, 0));
    // IO isolation and unmapped offsets
    vecs.push_back(mk(1, IO + 18'h3, 18'h00055, 0, C_RWE | C_GP, 0, 0, 0, 0, 18'h00055));
    vecs.push_back(mk(0, IO + 18'h3, 0, 0, C_RWE | C_OUT, 0, 18'h00055, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h0, 0, 0, C_OUT, 0, 18'h0, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h10, 0, 0, C_OUT, 0, 18'h0, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h4, 0, 0, C_OUT, 0, 18'h0, 0, 0, 0));
    vecs.push_back(mk(0, 18'h00303, 0, 0, C_OUT, 0, 18'h0ABCD, 0, 0, 0));
    // FIFO fill with overflow, then drain in order
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(1, IO, 18'(i), 0, C_RWE | C_TX, 0, 0, 1, 8'h01, 0));
    vecs.push_back(mk(0, IO + 18'h1, 0, 0, C_OUT | C_TX, 0, 18'h00046, 1, 8'h01, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, (k < 8), 8'(k + 1), 0));
    vecs.push_back(mk(0, IO + 18'h1, 0, 0, C_OUT, 0, 18'h00005, 0, 0, 0));
    vecs.push_back(mk(1, IO + 18'h1, 18'h00004, 0, C_RWE, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h1, 0, 0, C_OUT, 0, 18'h00001, 0, 0, 0));
    // Push and pop request together while empty: push only
    vecs.push_back(mk(1, IO, 18'h00077, 1, C_TX, 0, 0, 1, 8'h77, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 0, 0, 0));
    // Push into full FIFO with simultaneous pop
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, IO, 18'(8'h11 + i), 0, C_TX, 0, 0, 1, 8'h11, 0));
    vecs.push_back(mk(1, IO, 18'h000AA, 1, C_TX, 0, 0, 1, 8'h12, 0));
    vecs.push_back(mk(0, IO + 18'h1, 0, 0, C_OUT | C_TX, 0, 18'h00042, 1, 8'h12, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h13, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h14, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h15, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h16, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h17, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h18, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'hAA, 0));
    vecs.push_back(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 0, 0, 0));
    // Timer load and wrap
    vecs.push_back(mk(1, IO + 18'h2, 18'h3FFFE, 0, C_RWE, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h2, 0, 0, C_OUT, 0, 18'h3FFFE, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h2, 0, 0, C_OUT, 0, 18'h3FFFF, 0, 0, 0));
    vecs.push_back(mk(0, IO + 18'h2, 0, 0, C_OUT, 0, 18'h00000, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset tx_valid", 18'(tx_valid), 18'h0);
    chk("reset gpio", gpio_out, 18'h0);
    chk("reset rdata", cpu_memory_out, 18'h0);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a drain
    for (int i = 0; i < 5; i++)
      step(mk(1, IO, 18'(8'h21 + i), 0, C_TX, 0, 0, 1, 8'h21, 0), $sformatf("rq%0d", i));
    step(mk(1, IO + 18'h3, 18'h001FF, 0, C_GP, 0, 0, 0, 0, 18'h001FF), "rgpio");
    step(mk(0, 18'h0, 0, 1, C_TX, 0, 0, 1, 8'h22, 0), "rdrain");
    reset = 1'b1;
    step(mk(0, IO + 18'h3, 0, 1, C_OUT | C_TX | C_GP, 0, 18'h0ABCD, 0, 0, 18'h0), "rcycle");
    reset = 1'b0;
    step(mk(0, IO + 18'h2, 0, 1, C_OUT | C_TX, 0, 18'h00000, 0, 0, 0), "rtimer");
    step(mk(0, IO + 18'h1, 0, 0, C_OUT, 0, 18'h00001, 0, 0, 0), "rstatus");
    step(mk(0, IO + 18'h3, 0, 0, C_OUT | C_GP, 0, 18'h00000, 0, 0, 18'h0), "rgpiord");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
